// File: rtl/tdc_hit_scheduler.sv
// tdc_hit_scheduler: stamps two TDC channels with a coarse count, aligns the stamp to
// the fine-code decoder latency, buffers per channel and round-robins onto one stream.
module tdc_hit_scheduler #(
   parameter int DEC_LAT    = 7,
   parameter int COARSE_W   = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clr_status,
   input  logic                hit1,
   input  logic                hit2,
   input  logic [5:0]          fine1,
   input  logic [5:0]          fine2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_chan,
   output logic [COARSE_W-1:0] out_coarse,
   output logic [5:0]          out_fine,
   output logic                overflow1,
   output logic                overflow2,
   output logic [COARSE_W-1:0] coarse_now
);
   localparam int W  = COARSE_W + 6;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic [1:0]          ne, pop, ovf;
   logic [W-1:0]        head [2];

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [DEC_LAT-1:0]  tv_q, tv_d;
      logic [COARSE_W-1:0] tc_q [DEC_LAT];
      logic [COARSE_W-1:0] tc_d [DEC_LAT];
      logic [W-1:0]        mem_q [FIFO_DEPTH];
      logic [W-1:0]        mem_d [FIFO_DEPTH];
      logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
      logic [AW:0]         cnt_q, cnt_d;
      logic                ovf_q, ovf_d, push, valid_out;
      always_comb begin
         tv_d = {tv_q[DEC_LAT-2:0], (c == 0 ? hit1 : hit2) & enable};
         tc_d[0] = coarse_q;
         for (int i = 1; i < DEC_LAT; i++) tc_d[i] = tc_q[i-1];
         valid_out = tv_q[DEC_LAT-1];
         // a pop on the same edge frees the slot the push needs
         push = valid_out & (cnt_q != FULL || pop[c]);
         mem_d = mem_q;
         if (push) mem_d[wp_q] = {tc_q[DEC_LAT-1], c == 0 ? fine1 : fine2};
         wp_d = wp_q + AW'(push);
         rp_d = rp_q + AW'(pop[c]);
         cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop[c]};
         ovf_d = (valid_out & ~push) | (ovf_q & ~clr_status);
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            tv_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEC_LAT; i++) tc_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         end else begin
            tv_q  <= tv_d;
            tc_q  <= tc_d;
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end
      assign ne[c]   = cnt_q != '0;
      assign head[c] = mem_q[rp_q];
      assign ovf[c]  = ovf_q;
   end

   logic                out_valid_q, out_valid_d, out_chan_q, out_chan_d, last_q, last_d;
   logic [COARSE_W-1:0] out_coarse_q, out_coarse_d;
   logic [5:0]          out_fine_q, out_fine_d;
   logic                load, gnt2, take;

   always_comb begin
      coarse_d = enable ? coarse_q + COARSE_W'(1) : coarse_q;
      load = ~out_valid_q | out_ready;
      // last_q=1 means channel 2 was granted last, so channel 1 wins a tie
      gnt2 = ne[1] & (~ne[0] | ~last_q);
      take = load & (|ne);
      pop = take ? {gnt2, ~gnt2} : 2'b00;
      out_valid_d = load ? (|ne) : out_valid_q;
      out_chan_d = take ? gnt2 : out_chan_q;
      {out_coarse_d, out_fine_d} = take ? head[gnt2] : {out_coarse_q, out_fine_q};
      last_d = take ? gnt2 : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coarse_q     <= '0;
         out_valid_q  <= 1'b0;
         out_chan_q   <= 1'b0;
         out_coarse_q <= '0;
         out_fine_q   <= '0;
         last_q       <= 1'b1;
      end else begin
         coarse_q     <= coarse_d;
         out_valid_q  <= out_valid_d;
         out_chan_q   <= out_chan_d;
         out_coarse_q <= out_coarse_d;
         out_fine_q   <= out_fine_d;
         last_q       <= last_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_chan   = out_chan_q;
   assign out_coarse = out_coarse_q;
   assign out_fine   = out_fine_q;
   assign overflow1  = ovf[0];
   assign overflow2  = ovf[1];
   assign coarse_now = coarse_q;
endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// tb_tdc_hit_scheduler: directed checks of stamping, arbitration, overflow, wrap,
// enable gating and reset; a 4-bit coarse instance covers counter wrap.
module tb_tdc_hit_scheduler;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, clr_status = 1'b0;
   logic        hit1 = 1'b0, hit2 = 1'b0, out_ready = 1'b1;
   logic [5:0]  fine1 = '0, fine2 = '0;
   logic        out_valid, out_chan, overflow1, overflow2;
   logic [23:0] out_coarse, coarse_now;
   logic [5:0]  out_fine;
   logic        w_valid, w_chan, w_ovf1, w_ovf2;
   logic [3:0]  w_coarse, w_now;
   logic [5:0]  w_fine;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   tdc_hit_scheduler u_dut (
      .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
      .hit1(hit1), .hit2(hit2), .fine1(fine1), .fine2(fine2),
      .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
      .out_coarse(out_coarse), .out_fine(out_fine),
      .overflow1(overflow1), .overflow2(overflow2), .coarse_now(coarse_now)
   );

   tdc_hit_scheduler #(.COARSE_W(4)) u_w (
      .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
      .hit1(hit1), .hit2(hit2), .fine1(fine1), .fine2(fine2),
      .out_valid(w_valid), .out_ready(out_ready), .out_chan(w_chan),
      .out_coarse(w_coarse), .out_fine(w_fine),
      .overflow1(w_ovf1), .overflow2(w_ovf2), .coarse_now(w_now)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_word(input string tag, input logic ch, input logic [23:0] crs, input logic [5:0] fn);
      check({tag, " valid"}, 32'(out_valid), 1);
      check({tag, " chan"}, 32'(out_chan), 32'(ch));
      check({tag, " coarse"}, 32'(out_coarse), 32'(crs));
      check({tag, " fine"}, 32'(out_fine), 32'(fn));
   endtask

   task automatic do_reset;
      rst = 1'b1; enable = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
      out_ready = 1'b1; clr_status = 1'b0;
      steps(1);
      rst = 1'b0; enable = 1'b1;
   endtask

   initial begin
      #1;
      // basic stamp and reset state
      do_reset;
      check("rst valid", 32'(out_valid), 0);
      check("rst chan", 32'(out_chan), 0);
      check("rst coarse", 32'(out_coarse), 0);
      check("rst fine", 32'(out_fine), 0);
      check("rst ovf1", 32'(overflow1), 0);
      check("rst ovf2", 32'(overflow2), 0);
      check("rst now", 32'(coarse_now), 0);
      fine1 = 6'd23;
      steps(10);
      check("t1 now", 32'(coarse_now), 10);
      hit1 = 1'b1;
      steps(1);
      hit1 = 1'b0;
      steps(7);
      check("t1 early", 32'(out_valid), 0);
      steps(1);
      expect_word("t1", 1'b0, 24'd10, 6'd23);
      steps(1);
      check("t1 after", 32'(out_valid), 0);

      // simultaneous hits and round-robin
      do_reset;
      steps(5);
      hit1 = 1'b1; hit2 = 1'b1;
      steps(2);
      hit1 = 1'b0; hit2 = 1'b0;
      steps(5);
      fine1 = 6'd12; fine2 = 6'd30;
      steps(1);
      fine1 = 6'd13; fine2 = 6'd31;
      steps(1);
      expect_word("t2 a", 1'b0, 24'd5, 6'd12);
      steps(1);
      expect_word("t2 b", 1'b1, 24'd5, 6'd30);
      steps(1);
      expect_word("t2 c", 1'b0, 24'd6, 6'd13);
      steps(1);
      expect_word("t2 d", 1'b1, 24'd6, 6'd31);
      steps(1);
      check("t2 idle", 32'(out_valid), 0);

      // overflow with a stalled consumer
      do_reset;
      out_ready = 1'b0; fine1 = 6'd7;
      steps(20);
      hit1 = 1'b1;
      steps(6);
      hit1 = 1'b0;
      steps(7);
      expect_word("t3 head", 1'b0, 24'd20, 6'd7);
      check("t3 ovf1", 32'(overflow1), 1);
      check("t3 ovf2", 32'(overflow2), 0);
      steps(1);
      expect_word("t3 hold", 1'b0, 24'd20, 6'd7);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         steps(1);
         expect_word("t3 drain", 1'b0, 24'(20 + i), 6'd7);
      end
      steps(1);
      check("t3 empty", 32'(out_valid), 0);
      check("t3 sticky", 32'(overflow1), 1);
      clr_status = 1'b1;
      steps(1);
      clr_status = 1'b0;
      check("t3 clr", 32'(overflow1), 0);

      // coarse wrap on the 4-bit instance
      do_reset;
      fine1 = 6'd9;
      steps(15);
      check("t4 now15", 32'(w_now), 15);
      hit1 = 1'b1;
      steps(2);
      hit1 = 1'b0;
      check("t4 now1", 32'(w_now), 1);
      steps(7);
      check("t4 valid a", 32'(w_valid), 1);
      check("t4 coarse a", 32'(w_coarse), 15);
      steps(1);
      check("t4 valid b", 32'(w_valid), 1);
      check("t4 coarse b", 32'(w_coarse), 0);
      check("t4 now9", 32'(w_now), 9);

      // enable gating
      do_reset;
      fine1 = 6'd17;
      steps(8);
      hit1 = 1'b1;
      steps(1);
      hit1 = 1'b0; enable = 1'b0;
      steps(1);
      hit1 = 1'b1;
      steps(1);
      hit1 = 1'b0;
      check("t5 frozen", 32'(coarse_now), 9);
      steps(6);
      expect_word("t5", 1'b0, 24'd8, 6'd17);
      for (int i = 0; i < 2; i++) begin
         steps(1);
         check("t5 ignored", 32'(out_valid), 0);
      end
      check("t5 still", 32'(coarse_now), 9);

      // reset mid-stream
      do_reset;
      out_ready = 1'b0; fine1 = 6'd5;
      steps(3);
      hit1 = 1'b1;
      steps(3);
      hit1 = 1'b0;
      steps(2);
      hit1 = 1'b1;
      steps(3);
      hit1 = 1'b0;
      steps(2);
      expect_word("t6 pre", 1'b0, 24'd3, 6'd5);
      do_reset;
      check("t6 valid", 32'(out_valid), 0);
      check("t6 now", 32'(coarse_now), 0);
      fine1 = 6'd40;
      steps(2);
      hit1 = 1'b1;
      steps(1);
      hit1 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         steps(1);
         check("t6 stale", 32'(out_valid), 0);
      end
      steps(1);
      expect_word("t6 post", 1'b0, 24'd2, 6'd40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
